// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one multi-cycle ALU between two requesters.
// Round-robin grant, operands held stable while the ALU works, result
// returned on a tagged valid/ready response channel. Illegal opcodes are
// answered without touching the ALU, and a stuck ALU is cut off by a timeout.
module alu_req_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_hi,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_hi,

  output logic [WIDTH-1:0] alu_num_1,
  output logic [WIDTH-1:0] alu_num_2,
  output logic [WIDTH-1:0] alu_sub_reg_input,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_sub_reg_result,
  input  logic             alu_done,
  input  logic [3:0]       alu_flag,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0] resp_sub,
  output logic [3:0]       resp_flag,
  output logic [1:0]       resp_status
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0]  OP_IDLE       = 4'b1111;
  localparam logic [3:0]  LAST_LEGAL_OP = 4'd8;
  localparam logic [3:0]  FLAG_ERR      = 4'b1111;
  localparam logic [1:0]  STAT_OK       = 2'b00;
  localparam logic [1:0]  STAT_ILLEGAL  = 2'b01;
  localparam logic [1:0]  STAT_TIMEOUT  = 2'b10;
  localparam logic [16:0] TIMEOUT_VAL   = 17'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sub_q, sub_d;
  logic [3:0]       flag_q, flag_d;
  logic [1:0]       status_q, status_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             grant_valid;
  logic             grant_id;
  logic [3:0]       sel_opcode;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] sel_hi;
  logic [16:0]      cnt_inc;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_id_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Select the winning requester's payload for latching
  always_comb begin
    sel_opcode = req0_opcode;
    sel_a      = req0_a;
    sel_b      = req0_b;
    sel_hi     = req0_hi;
    if (grant_id) begin
      sel_opcode = req1_opcode;
      sel_a      = req1_a;
      sel_b      = req1_b;
      sel_hi     = req1_hi;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant_valid && !grant_id;
  assign req1_ready = (state_q == IDLE) && grant_valid &&  grant_id;

  // Next-state logic: accept, issue, wait for done or timeout, hold response
  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    id_d      = id_q;
    res_d     = res_q;
    sub_d     = sub_q;
    flag_d    = flag_q;
    status_d  = status_q;
    cnt_d     = cnt_q;
    cnt_inc   = {1'b0, cnt_q} + 17'd1;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d      = grant_id;
          last_id_d = grant_id;
          op_d      = sel_opcode;
          if (sel_opcode <= LAST_LEGAL_OP) begin
            a_d     = sel_a;
            b_d     = sel_b;
            hi_d    = sel_hi;
            state_d = ISSUE;
          end else begin
            res_d    = '0;
            sub_d    = '0;
            flag_d   = FLAG_ERR;
            status_d = STAT_ILLEGAL;
            state_d  = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          res_d    = alu_result;
          sub_d    = alu_sub_reg_result;
          flag_d   = alu_flag;
          status_d = STAT_OK;
          state_d  = RESP;
        end else if (cnt_inc == TIMEOUT_VAL) begin
          res_d    = '0;
          sub_d    = '0;
          flag_d   = FLAG_ERR;
          status_d = STAT_TIMEOUT;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation and favours requester 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_id_q <= 1'b1;
      op_q      <= OP_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      id_q      <= 1'b0;
      res_q     <= '0;
      sub_q     <= '0;
      flag_q    <= '0;
      status_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      id_q      <= id_d;
      res_q     <= res_d;
      sub_q     <= sub_d;
      flag_q    <= flag_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
    end
  end

  assign alu_opcode        = ((state_q == ISSUE) || (state_q == WAIT)) ? op_q : OP_IDLE;
  assign alu_num_1         = a_q;
  assign alu_num_2         = b_q;
  assign alu_sub_reg_input = hi_q;

  assign resp_valid  = (state_q == RESP);
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign resp_sub    = sub_q;
  assign resp_flag   = flag_q;
  assign resp_status = status_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed bench for alu_req_arbiter with a small
// behavioural ALU whose done can be forced same-cycle or never.
module tb_alu_req_arbiter;

  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req0_ready;
  logic [3:0]   req0_opcode;
  logic [W-1:0] req0_a, req0_b, req0_hi;
  logic         req1_valid, req1_ready;
  logic [3:0]   req1_opcode;
  logic [W-1:0] req1_a, req1_b, req1_hi;
  logic [W-1:0] alu_num_1, alu_num_2, alu_sub_reg_input;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_result, alu_sub_reg_result;
  logic         alu_done;
  logic [3:0]   alu_flag;
  logic         resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_result, resp_sub;
  logic [3:0]   resp_flag;
  logic [1:0]   resp_status;

  logic         alu_done_enable;
  int           n_cmp = 0;
  int           n_err = 0;

  alu_req_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_hi(req0_hi),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_hi(req1_hi),
    .alu_num_1(alu_num_1), .alu_num_2(alu_num_2), .alu_sub_reg_input(alu_sub_reg_input),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_sub_reg_result(alu_sub_reg_result),
    .alu_done(alu_done), .alu_flag(alu_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_sub(resp_sub), .resp_flag(resp_flag),
    .resp_status(resp_status)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: combinational result, done whenever an opcode is driven and enabled
  always_comb begin
    logic [2*W-1:0] prod;
    prod               = {{W{1'b0}}, alu_num_1} * {{W{1'b0}}, alu_num_2};
    alu_result         = '0;
    alu_sub_reg_result = '0;
    case (alu_opcode)
      OP_ADD: alu_result = alu_num_1 + alu_num_2;
      OP_SUB: alu_result = alu_num_1 - alu_num_2;
      OP_MUL: begin
        alu_result         = prod[W-1:0];
        alu_sub_reg_result = prod[2*W-1:W];
      end
      OP_DIV: begin
        if (alu_num_2 != '0) begin
          alu_result         = alu_num_1 / alu_num_2;
          alu_sub_reg_result = alu_num_1 % alu_num_2;
        end
      end
      OP_AND: alu_result = alu_num_1 & alu_num_2;
      default: alu_result = '0;
    endcase
    alu_flag = {1'b0, (alu_result == '0), alu_result[W-1], 1'b0};
    alu_done = alu_done_enable && (alu_opcode != 4'b1111);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit which, input bit valid, input logic [3:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b);
    if (!which) begin
      req0_valid = valid; req0_opcode = op; req0_a = a; req0_b = b; req0_hi = '0;
    end else begin
      req1_valid = valid; req1_opcode = op; req1_a = a; req1_b = b; req1_hi = '0;
    end
    #1;
  endtask

  task automatic wait_resp(input int max_cycles, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < max_cycles) begin
      tick();
      cycles++;
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Directed sequence covering latency, fairness, timeout, illegal opcode, backpressure and reset
  initial begin
    int  cyc;
    bit  ok;
    bit  exp_id;

    reset_n = 1'b0;
    req0_valid = 0; req0_opcode = '0; req0_a = '0; req0_b = '0; req0_hi = '0;
    req1_valid = 0; req1_opcode = '0; req1_a = '0; req1_b = '0; req1_hi = '0;
    resp_ready = 1'b0;
    alu_done_enable = 1'b1;
    #2;

    // reset values
    check_output("rst_alu_opcode", alu_opcode, 4'hF);
    check_output("rst_num_1", alu_num_1, 0);
    check_output("rst_num_2", alu_num_2, 0);
    check_output("rst_sub_in", alu_sub_reg_input, 0);
    check_output("rst_ready", {req0_ready, req1_ready}, 0);
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_resp_fields", {resp_id, resp_flag, resp_status}, 0);
    check_output("rst_resp_data", {resp_result, resp_sub}, 0);
    tick();
    reset_n = 1'b1;
    #1;

    // 1: AND latency with same-cycle done
    $display("[TB] test 1: AND latency");
    apply_stimulus(0, 1, OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check_output("t1_ready", {req0_ready, req1_ready}, 2'b10);
    tick();
    apply_stimulus(0, 0, 4'd0, 0, 0);
    check_output("t1_issue_op", alu_opcode, OP_AND);
    check_output("t1_issue_valid", resp_valid, 0);
    tick();
    check_output("t1_wait_op", alu_opcode, OP_AND);
    check_output("t1_wait_valid", resp_valid, 0);
    tick();
    check_output("t1_valid", resp_valid, 1);
    check_output("t1_result", resp_result, 32'h00F0_000F);
    check_output("t1_flag", resp_flag, 4'b0000);
    check_output("t1_id_status", {resp_id, resp_status}, 3'b000);
    check_output("t1_resp_op", alu_opcode, 4'hF);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_output("t1_after_valid", resp_valid, 0);

    // 2: round-robin with both requesters continuously valid
    $display("[TB] test 2: round robin");
    do_reset();
    resp_ready = 1'b1;
    apply_stimulus(0, 1, OP_ADD, 32'd3, 32'd4);
    apply_stimulus(1, 1, OP_SUB, 32'd10, 32'd3);
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      cyc = 0;
      while (!(req0_ready || req1_ready) && cyc < 20) begin
        check_output("t2_one_hot_wait", req0_ready & req1_ready, 0);
        tick();
        cyc++;
      end
      check_output("t2_grant", {req0_ready, req1_ready}, exp_id ? 2'b01 : 2'b10);
      check_output("t2_idle_op", alu_opcode, 4'hF);
      tick();
      wait_resp(20, cyc, ok);
      check_output("t2_resp_seen", ok, 1);
      check_output("t2_id", resp_id, exp_id);
      check_output("t2_result", resp_result, 32'd7);
      check_output("t2_status", resp_status, 2'b00);
      check_output("t2_one_hot_resp", req0_ready | req1_ready, 0);
      tick();
    end
    apply_stimulus(0, 0, 4'd0, 0, 0);
    apply_stimulus(1, 0, 4'd0, 0, 0);
    resp_ready = 1'b0;

    // 3: timeout after 8 WAIT cycles
    $display("[TB] test 3: timeout");
    alu_done_enable = 1'b0;
    apply_stimulus(0, 1, OP_ADD, 32'd1, 32'd2);
    tick();
    apply_stimulus(0, 0, 4'd0, 0, 0);
    tick();
    check_output("t3_wait_op", alu_opcode, OP_ADD);
    wait_resp(50, cyc, ok);
    check_output("t3_resp_seen", ok, 1);
    check_output("t3_wait_cycles", cyc, 8);
    check_output("t3_status", resp_status, 2'b10);
    check_output("t3_result", {resp_result, resp_sub}, 0);
    check_output("t3_flag", resp_flag, 4'b1111);
    check_output("t3_op_idle", alu_opcode, 4'hF);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    alu_done_enable = 1'b1;

    // 4: illegal opcode from requester 1
    $display("[TB] test 4: illegal opcode");
    apply_stimulus(1, 1, 4'b1010, 32'h1234, 32'h5678);
    check_output("t4_ready", {req0_ready, req1_ready}, 2'b01);
    check_output("t4_accept_op", alu_opcode, 4'hF);
    tick();
    apply_stimulus(1, 0, 4'd0, 0, 0);
    check_output("t4_valid", resp_valid, 1);
    check_output("t4_id", resp_id, 1);
    check_output("t4_status", resp_status, 2'b01);
    check_output("t4_flag", resp_flag, 4'b1111);
    check_output("t4_result", {resp_result, resp_sub}, 0);
    check_output("t4_resp_op", alu_opcode, 4'hF);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // 5: MUL with response backpressure
    $display("[TB] test 5: MUL backpressure");
    apply_stimulus(0, 1, OP_MUL, 32'h0001_0000, 32'h0001_0000);
    check_output("t5_ready", {req0_ready, req1_ready}, 2'b10);
    tick();
    apply_stimulus(1, 1, OP_ADD, 32'd5, 32'd6);
    check_output("t5_issue_ready", {req0_ready, req1_ready}, 0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check_output("t5_valid", resp_valid, 1);
      check_output("t5_result", resp_result, 0);
      check_output("t5_sub", resp_sub, 1);
      check_output("t5_ready_low", {req0_ready, req1_ready}, 0);
      tick();
    end
    apply_stimulus(0, 0, 4'd0, 0, 0);
    apply_stimulus(1, 0, 4'd0, 0, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_output("t5_done", resp_valid, 0);

    // 6: reset during DIV WAIT
    $display("[TB] test 6: reset mid-operation");
    alu_done_enable = 1'b0;
    apply_stimulus(0, 1, OP_DIV, 32'd100, 32'd7);
    tick();
    apply_stimulus(0, 0, 4'd0, 0, 0);
    tick();
    tick();
    check_output("t6_wait_op", alu_opcode, OP_DIV);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_op", alu_opcode, 4'hF);
    check_output("t6_rst_num", {alu_num_1, alu_num_2}, 0);
    check_output("t6_rst_valid", resp_valid, 0);
    check_output("t6_rst_fields", {resp_id, resp_flag, resp_status}, 0);
    tick();
    reset_n = 1'b1;
    alu_done_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("t6_no_resp", resp_valid, 0);
    end
    apply_stimulus(0, 1, OP_ADD, 32'd1, 32'd1);
    apply_stimulus(1, 1, OP_ADD, 32'd2, 32'd2);
    check_output("t6_grant0", {req0_ready, req1_ready}, 2'b10);
    apply_stimulus(0, 0, 4'd0, 0, 0);
    apply_stimulus(1, 0, 4'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU instance between two requesters, issuing one operation at a time.
- Round-robin arbitration between the requesters.
- Drives the ALU's num_1, num_2, sub_reg_input and opcode inputs, and holds them stable until the ALU reports done.
- Captures result, sub_reg_result and flag, and returns them on a single valid/ready response channel tagged with the requester id.
- Provides timeout and illegal-opcode protection.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
TIMEOUT_CYCLES, 256, maximum WAIT cycles before an operation is aborted (1..65535).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_opcode  in  4  ALU opcode, 0..8 legal
req0_a  in  WIDTH  operand to num_1
req0_b  in  WIDTH  operand to num_2
req0_hi  in  WIDTH  dividend high word to sub_reg_input
req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_hi  same as requester 0, for requester 1
alu_num_1  out  WIDTH  to ALU num_1
alu_num_2  out  WIDTH  to ALU num_2
alu_sub_reg_input  out  WIDTH  to ALU sub_reg_input
alu_opcode  out  4  to ALU opcode; 4'b1111 = idle
alu_result  in  WIDTH  from ALU result
alu_sub_reg_result  in  WIDTH  from ALU sub_reg_result
alu_done  in  1  from ALU done
alu_flag  in  4  from ALU flag {overflow, zero, sign, carry}
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_id  out  1  requester that issued the operation
resp_result  out  WIDTH  captured result
resp_sub  out  WIDTH  captured sub_reg_result (MUL high word / DIV remainder)
resp_flag  out  4  captured flag
resp_status  out  2  00 ok, 01 illegal opcode, 10 timeout

Behaviour:
Reset (reset_n low, takes effect immediately, also mid-operation):
- State IDLE; all outputs 0 except alu_opcode = 4'b1111.
- Round-robin pointer set so requester 0 wins the first tie.
- Timeout counter cleared; any in-flight operation is dropped with no response.

States: IDLE, ISSUE, WAIT, RESP.

IDLE:
- grant = the only valid requester; on a tie, the requester not served last.
- reqN_ready = (state==IDLE) & grant==N. It is combinational from the valid inputs, and at most one ready is high.
- Accept on valid & ready: latch opcode, a, b, hi and id; update the round-robin pointer to id.
- Legal opcode (0..8): go to ISSUE.
- Illegal opcode (9..15): go directly to RESP with status 01, result 0, sub 0, flag 4'b1111. The ALU is never driven.

ISSUE (exactly 1 cycle):
- alu_opcode and operands come from the latched registers.
- alu_done is ignored, to discard stale done from the previous operation.
- Go to WAIT.

WAIT:
- Operands and opcode are held.
- Rising edge with alu_done=1: capture alu_result, alu_sub_reg_result and alu_flag; status 00; go to RESP.
- Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES without done: status 10, result 0, sub 0, flag 4'b1111; go to RESP.
- The counter clears on entering WAIT.

RESP:
- alu_opcode = 4'b1111; operands keep their last values.
- resp_valid = 1; all resp_* signals stay stable until resp_valid & resp_ready, then go to IDLE.
- Both readys are low throughout RESP.

Latency:
- For an ALU with same-cycle done (logic ops), the accepting edge is E0, E1 enters WAIT, E2 captures, and resp_valid is high after E2.
- The earliest next acceptance is in the cycle after the response handshake, which guarantees at least one idle-opcode cycle between operations.

Other rules:
- resp_valid never depends combinationally on resp_ready.
- Requester inputs are don't-care outside the accept cycle.

Test Plan:
1. req0 AND (opcode 5), a=32'hF0F0_00FF, b=32'h0FF0_0F0F; ALU model with same-cycle done -> resp_valid after 2nd edge post-accept; result 32'h00F0_000F, flag 4'b0000, id 0, status 00.
2. Both requesters valid continuously after reset with ADD 3+4 and SUB 10-3 -> grant order 0,1,0,1; results 7, 7, 7, 7; ready never high on both simultaneously.
3. TIMEOUT_CYCLES=8; model never asserts done -> exactly 8 WAIT cycles, then resp status 10, result 0, flag 4'b1111; alu_opcode returns to 4'b1111.
4. req1 opcode 4'b1010 -> ALU opcode stays 4'b1111 throughout; response id 1, status 01, flag 4'b1111 on the edge after accept.
5. MUL 32'h0001_0000 * 32'h0001_0000, resp_ready held low 5 cycles -> resp_result 0, resp_sub 1, stable for all 5 cycles; req0_ready and req1_ready low until the handshake.
6. reset_n pulled low during WAIT of DIV -> all outputs at reset values immediately with no response; the next request after release is granted to requester 0.
